// File: rtl/cp_remove_if.sv
// Sample-stream bundle between the radio front end, cp_remove and the FFT core.
// The slave side is the cp_remove block; the master side feeds samples and takes bursts.
interface cp_remove_if #(
    parameter int DATA_NBIT = 16
);
    logic                 fft_type;
    logic                 cp_type;
    logic [1:0]           num_pat;
    logic                 din_h;
    logic                 din_s;
    logic                 din_v;
    logic [DATA_NBIT-1:0] din_i;
    logic [DATA_NBIT-1:0] din_q;
    logic                 dout_sop;
    logic                 dout_valid;
    logic [DATA_NBIT-1:0] dout_real;
    logic [DATA_NBIT-1:0] dout_imag;
    logic                 dout_eop;
    logic                 dout_fst_cp;
    logic                 err_short;
    logic                 err_ovf;

    modport master (
        output fft_type, cp_type, num_pat, din_h, din_s, din_v, din_i, din_q,
        input  dout_sop, dout_valid, dout_real, dout_imag, dout_eop, dout_fst_cp,
        input  err_short, err_ovf
    );

    modport slave (
        input  fft_type, cp_type, num_pat, din_h, din_s, din_v, din_i, din_q,
        output dout_sop, dout_valid, dout_real, dout_imag, dout_eop, dout_fst_cp,
        output err_short, err_ovf
    );
endinterface

// File: rtl/cp_remove.sv
// Strips the cyclic prefix of each OFDM symbol, parks the body in a ping-pong RAM and bursts
// it to the FFT core one sample per clock. Define CP_SCALE_EN to scale CP length with num_pat.
module cp_remove #(
    parameter int DATA_NBIT = 16
) (
    input logic        clk,
    input logic        reset,
    cp_remove_if.slave bus
);
    typedef enum logic [1:0] {W_IDLE, W_CP, W_SYM} wstate_t;
    typedef enum logic {R_IDLE, R_BURST} rstate_t;
    localparam int WORD_W = 2 * DATA_NBIT;

    logic        start;
    logic [11:0] n_new;
    logic [9:0]  cp_base;
    logic [9:0]  c_new;

    assign start   = bus.din_v & bus.din_h;
    assign n_new   = 12'd2048 - {1'b0, bus.num_pat, 9'd0};
    assign cp_base = bus.cp_type ? 10'd512 : (bus.din_s ? 10'd160 : 10'd144);
`ifdef CP_SCALE_EN
    logic [9:0] cp_quarter;
    logic [9:0] cp_mult;
    assign cp_quarter = cp_base >> 2;
    assign cp_mult    = 10'd4 - {8'd0, bus.num_pat};
    assign c_new      = bus.fft_type ? 10'd0 : cp_quarter * cp_mult;
`else
    assign c_new      = bus.fft_type ? 10'd0 : cp_base;
`endif

    wstate_t     w_state_q, w_state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] n_q, n_d;
    logic [9:0]  c_q, c_d;
    logic        fst_q, fst_d;
    logic        wr_bank_q;
    logic        wr_en, done, abort;
    logic [10:0] wr_addr;
    logic        err_short_q, rd_req_q, req_fst_q, req_bank_q;
    logic [11:0] req_n_q;

    always_comb begin
        w_state_d = w_state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        c_d       = c_q;
        fst_d     = fst_q;
        wr_en     = 1'b0;
        wr_addr   = cnt_q[10:0];
        done      = 1'b0;
        abort     = 1'b0;
        if (start) begin
            // A header always restarts the symbol, even mid-way through the previous one
            abort = (w_state_q != W_IDLE);
            n_d   = n_new;
            c_d   = c_new;
            fst_d = bus.din_s;
            cnt_d = 12'd1;
            if (c_new == 10'd0) begin
                w_state_d = W_SYM;
                wr_en     = 1'b1;
                wr_addr   = '0;
            end else begin
                w_state_d = W_CP;
            end
        end else if (bus.din_v) begin
            case (w_state_q)
                W_CP: begin
                    if (cnt_q == {2'd0, c_q} - 12'd1) begin
                        w_state_d = W_SYM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                W_SYM: begin
                    wr_en = 1'b1;
                    if (cnt_q == n_q - 12'd1) begin
                        done      = 1'b1;
                        w_state_d = W_IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state_q   <= W_IDLE;
            cnt_q       <= '0;
            wr_bank_q   <= 1'b0;
            rd_req_q    <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            cnt_q       <= cnt_d;
            rd_req_q    <= done;
            err_short_q <= abort;
            if (done) wr_bank_q <= ~wr_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        n_q   <= n_d;
        c_q   <= c_d;
        fst_q <= fst_d;
        if (done) begin
            req_n_q    <= n_q;
            req_fst_q  <= fst_q;
            req_bank_q <= wr_bank_q;
        end
    end

    rstate_t     r_state_q, r_state_d;
    logic [11:0] rcnt_q, rcnt_d;
    logic [11:0] rn_q, rn_d;
    logic        rd_bank_q, rd_bank_d, rfst_q, rfst_d;
    logic        pend_q, pend_d, ovf_q, ovf_d;
    logic        issue_p0;

    assign issue_p0 = (r_state_q == R_BURST);

    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rn_d      = rn_q;
        rd_bank_d = rd_bank_q;
        rfst_d    = rfst_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        if (rd_req_q && r_state_q == R_BURST) begin
            pend_d = 1'b1;
            ovf_d  = 1'b1;
        end
        case (r_state_q)
            R_IDLE: begin
                if (rd_req_q || pend_q) begin
                    rn_d      = req_n_q;
                    rd_bank_d = req_bank_q;
                    rfst_d    = req_fst_q;
                    pend_d    = 1'b0;
                    rcnt_d    = '0;
                    r_state_d = R_BURST;
                end
            end
            default: begin
                if (rcnt_q == rn_q - 12'd1) r_state_d = R_IDLE;
                else rcnt_d = rcnt_q + 12'd1;
            end
        endcase
    end

    logic [WORD_W-1:0] mem [0:4095];
    logic [WORD_W-1:0] rd_word_p1;
    logic              vld_p1_q, sop_p1_q, eop_p1_q, fst_p1_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank_q, wr_addr}] <= {bus.din_i, bus.din_q};
        // p0 -> p1: RAM read of the issued burst address
        rd_word_p1 <= mem[{rd_bank_q, rcnt_q[10:0]}];
        rn_q       <= rn_d;
        rd_bank_q  <= rd_bank_d;
        rfst_q     <= rfst_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            rcnt_q    <= '0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
            vld_p1_q  <= 1'b0;
            sop_p1_q  <= 1'b0;
            eop_p1_q  <= 1'b0;
            fst_p1_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rcnt_q    <= rcnt_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            vld_p1_q  <= issue_p0;
            sop_p1_q  <= issue_p0 && (rcnt_q == 12'd0);
            eop_p1_q  <= issue_p0 && (rcnt_q == rn_q - 12'd1);
            fst_p1_q  <= issue_p0 && rfst_q;
        end
    end

    assign bus.dout_valid  = vld_p1_q;
    assign bus.dout_sop    = sop_p1_q;
    assign bus.dout_eop    = eop_p1_q;
    assign bus.dout_fst_cp = fst_p1_q;
    assign bus.dout_real   = vld_p1_q ? rd_word_p1[WORD_W-1:DATA_NBIT] : '0;
    assign bus.dout_imag   = vld_p1_q ? rd_word_p1[DATA_NBIT-1:0] : '0;
    assign bus.err_short   = err_short_q;
    assign bus.err_ovf     = ovf_q;
endmodule

// File: doc/cp_remove.md
# cp_remove

Front-end pre-processor for the LTE FFT/IFFT core, the receive-side counterpart of the CP-inserting post-processor. It accepts time-domain samples at sample rate (one valid every few clocks), discards the cyclic prefix of each OFDM symbol and caches the remaining N samples in a ping-pong buffer. It then bursts each symbol into the FFT core at one sample per clock, framed with sop/valid/eop. In IFFT mode it frames N frequency-domain samples with no CP removal.

## Interface
- DATA_NBIT, 16, width of I and Q samples
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- fft_type  in  1  0 = FFT (strip CP), 1 = IFFT (no CP); sampled at symbol start
- cp_type  in  1  0 = normal, 1 = extended; sampled at symbol start
- num_pat  in  2  0 = 2048, 1 = 1536, 2 = 1024, 3 = 512 points; sampled at symbol start
- din_h  in  1  first sample of symbol (CP included); qualified by din_v
- din_s  in  1  symbol is first of slot; qualified by din_h&din_v
- din_v  in  1  input sample valid
- din_i, din_q  in  DATA_NBIT  input sample
- dout_sop  out  1  first output sample of symbol
- dout_valid  out  1  output sample valid
- dout_real, dout_imag  out  DATA_NBIT  output sample; 0 when dout_valid = 0
- dout_eop  out  1  last output sample of symbol
- dout_fst_cp  out  1  first-of-slot flag, held from dout_sop through dout_eop
- err_short  out  1  one-cycle pulse: symbol aborted by early din_h
- err_ovf  out  1  sticky: bank completed while other bank still being read; cleared only by reset

## Operation
- Symbol length N = 2048 − 512·num_pat (12-bit).
- CP length C: 0 if fft_type = 1; otherwise base × (4 − num_pat) / 4, with base 512 (extended), 160 (normal, din_s = 1) or 144 (normal, din_s = 0). Results: 2048 → 160/144/512, 1536 → 120/108/384, 1024 → 80/72/256, 512 → 40/36/128. Computed as (base>>2)·(4 − num_pat).
- fft_type, cp_type, num_pat, din_s, N and C latch on din_h&din_v and hold for the whole symbol.
- Write FSM:
  - W_IDLE: din_v without din_h is ignored. din_h&din_v goes to W_CP, with the current sample counted as CP sample 0; if C = 0 it goes to W_SYM and the sample is written to address 0.
  - W_CP: count valid samples. The sample after CP sample C−1 goes to W_SYM.
  - W_SYM: write valid samples to the write bank at addresses 0..N−1. After the write of N−1, toggle the write bank, issue a read request and return to W_IDLE.
  - din_h&din_v in W_CP or W_SYM: drop the partial symbol and pulse err_short in the next cycle. The bank is not toggled, and the sample restarts the symbol as in W_IDLE.
- Buffer: simple dual-port RAM of 2×2048 words of {I,Q}; the address MSB selects the bank.
- Read FSM:
  - R_IDLE: a read request latches N and the din_s flag, then enters R_BURST.
  - R_BURST: read addresses 0..N−1 of the bank just filled, one per clock, then return to R_IDLE.
  - A read request arriving while in R_BURST sets err_ovf. The running burst completes unchanged and the new request is then served.

## Timing
- All outputs reset to 0; both FSMs return to idle; no partial burst continues after reset deasserts.
- Latency: last symbol sample accepted in cycle T → dout_sop = dout_valid = 1 in cycle T+3 (request registered, RAM read, output registered).
- Burst: dout_valid is high for exactly N consecutive cycles. dout_sop is high on the first cycle and dout_eop on the last; they are never high in the same cycle.
- A simultaneous write to and read from different banks is always legal.
- A reset assertion mid-burst drops dout_valid in the next cycle.

## Configuration
- CP_SCALE_EN defined: CP length scales with num_pat as above.
- CP_SCALE_EN undefined: C = base (160/144/512) for every num_pat, and only the 2048 entries of the C table apply.

## Test plan
- 2048-point, normal, din_s = 1, one sample every 5 clocks, 2208 samples (sample k = k) → dout burst of 2048 with dout_real = 160..2207; dout_sop and dout_fst_cp high; dout_eop on value 2207; sop 3 cycles after the last input.
- 512-point, extended, 640 samples → 512 outputs starting at input sample 128; dout_fst_cp = 0.
- fft_type = 1, 1024-point, 1024 samples → 1024 outputs identical to the input and in order.
- 2048 normal, din_h again after 1000 samples → err_short pulses once, no burst for the aborted symbol, and the following full symbol outputs correctly.
- Back-to-back symbols with one sample per clock, so a bank completes while the other is still being read → err_ovf = 1 and stays set until reset.
- Reset asserted in the middle of a burst → dout_valid = 0 the next cycle, all outputs 0, and the next complete symbol is processed normally.
